// File: rtl/vilya_pin_pkg.sv
// ---------------------------------------------------------------------------
// vilya_pin_pkg
// Shared definitions for the device-to-host pin streaming path.
//   tx_state_t      : handshake FSM states of pin_stream_tx
//   BYTES_PER_WORD  : bytes sent per result word (LSB byte first)
//   SYNC_STAGES     : flops in the host_ack synchronizer
// ---------------------------------------------------------------------------
package vilya_pin_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        REQ,
        WAIT_LO
    } tx_state_t;

    localparam int BYTES_PER_WORD = 2;
    localparam int SYNC_STAGES    = 2;

endpackage

// File: rtl/pin_stream_tx_if.sv
// ---------------------------------------------------------------------------
// pin_stream_tx_if
// Bundles the core-side word handshake and the pin-side byte handshake.
//   in_valid / in_ready / in_data : core offers a word, transmitter accepts
//   tx_data / tx_req              : byte and request strobe towards the host
//   host_ack                      : acknowledge coming back from the host
// Modports:
//   master : the transmitter (pin_stream_tx)
//   slave  : the surrounding core plus the host side of the pins
// ---------------------------------------------------------------------------
interface pin_stream_tx_if #(
    parameter int DATA_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [7:0]        tx_data;
    logic              tx_req;
    logic              host_ack;

    modport master (
        input  in_valid,
        input  in_data,
        input  host_ack,
        output in_ready,
        output tx_data,
        output tx_req
    );

    modport slave (
        output in_valid,
        output in_data,
        output host_ack,
        input  in_ready,
        input  tx_data,
        input  tx_req
    );
endinterface

// File: rtl/pin_tx_fifo.sv
// ---------------------------------------------------------------------------
// pin_tx_fifo
// Small synchronous FIFO holding words waiting to go out on the pins.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset (empties the FIFO)
//   push       : write wr_data at the tail (caller guarantees !full)
//   wr_data    : word to store
//   pop        : drop the head entry (caller guarantees !empty)
//   rd_data    : head entry, shown combinationally
//   full/empty : occupancy flags
// Pointers carry one extra MSB so full and empty are distinguishable
// without a separate counter; DEPTH must be a power of two.
// ---------------------------------------------------------------------------
module pin_tx_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Storage array; contents need no reset because the pointers decide
    // what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Pointer registers; both wrap naturally through the extra MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Same index with differing MSB means the writer lapped the reader.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/pin_stream_tx.sv
// ---------------------------------------------------------------------------
// pin_stream_tx
// Sends 16-bit result words to an off-chip host as two bytes (LSB first)
// using a four-phase req/ack handshake on the Tiny Tapeout pins.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   ena        : TT enable; while low no new words are accepted, but a
//                word already in flight and queued words still go out
//   busy       : high while the FSM is active or words are queued
//   bus        : pin_stream_tx_if.master (core word handshake, tx_data,
//                tx_req and the asynchronous host_ack)
// ---------------------------------------------------------------------------
module pin_stream_tx
    import vilya_pin_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    output logic             busy,
    pin_stream_tx_if.master  bus
);
    tx_state_t               state_q;
    tx_state_t               state_d;
    logic                    byte_idx_q;
    logic                    byte_idx_d;
    logic [DATA_W-1:0]       word_q;
    logic [DATA_W-1:0]       word_d;
    logic [7:0]              tx_data_q;
    logic [7:0]              tx_data_d;
    logic                    tx_req_q;
    logic                    tx_req_d;
    logic [SYNC_STAGES-1:0]  ack_sync_q;
    logic                    ack_s;

    logic                    fifo_push;
    logic                    fifo_pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [DATA_W-1:0]       fifo_head;

    assign bus.in_ready = ena & ~fifo_full;
    assign fifo_push    = bus.in_valid & bus.in_ready;

    pin_tx_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (fifo_push),
        .wr_data (bus.in_data),
        .pop     (fifo_pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // host_ack is asynchronous to clk; only the last synchronizer stage
    // is ever looked at by the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_sync_q <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], bus.host_ack};
        end
    end

    assign ack_s = ack_sync_q[SYNC_STAGES-1];

    // Handshake state and the registered pin outputs. Because tx_req and
    // tx_data live here, reset drops tx_req immediately without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            byte_idx_q <= 1'b0;
            word_q     <= '0;
            tx_data_q  <= 8'h00;
            tx_req_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
            tx_data_q  <= tx_data_d;
            tx_req_q   <= tx_req_d;
        end
    end

    // Next-state logic. tx_data is only ever updated on the way into
    // SETUP, so it is already settled a full cycle before tx_req rises and
    // stays put until the host has released its ack. A host ack that is
    // still high in IDLE belongs to an earlier exchange, so the next word
    // waits for it to clear before starting.
    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        tx_data_d  = tx_data_q;
        tx_req_d   = tx_req_q;
        fifo_pop   = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty && !ack_s) begin
                    fifo_pop   = 1'b1;
                    word_d     = fifo_head;
                    tx_data_d  = fifo_head[7:0];
                    byte_idx_d = 1'b0;
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                tx_req_d = 1'b1;
                state_d  = REQ;
            end
            REQ: begin
                if (ack_s) begin
                    tx_req_d = 1'b0;
                    state_d  = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!ack_s) begin
                    if (byte_idx_q == 1'(BYTES_PER_WORD - 1)) begin
                        state_d = IDLE;
                    end else begin
                        tx_data_d  = word_q[DATA_W-1:8];
                        byte_idx_d = 1'b1;
                        state_d    = SETUP;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.tx_data = tx_data_q;
    assign bus.tx_req  = tx_req_q;
    assign busy        = (state_q != IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_pin_stream_tx.sv
// ---------------------------------------------------------------------------
// tb_pin_stream_tx
// Self-checking bench for pin_stream_tx. Every accepted word pushes its two
// bytes (LSB first) onto a scoreboard queue; a host model on the pin side
// acks each request and compares the captured byte with the queue head.
// ---------------------------------------------------------------------------
module tb_pin_stream_tx;
    import vilya_pin_pkg::*;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       busy;
    logic       host_force;
    logic       force_val;
    logic       host_normal;
    logic       host_model_ack = 1'b0;
    logic [7:0] exp_q [$];
    int         checks = 0;
    int         errors = 0;

    pin_stream_tx_if #(.DATA_W(DATA_W)) bus ();

    assign bus.host_ack = host_force ? force_val : host_model_ack;

    pin_stream_tx #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .busy  (busy),
        .bus   (bus)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Counts one comparison and reports it when it does not match.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [2:0] fifo_count();
        return dut.u_fifo.wr_ptr - dut.u_fifo.rd_ptr;
    endfunction

    // Host model: acks one cycle after tx_req rises, capturing the byte,
    // and releases one cycle after tx_req falls. Disabled while stalled.
    always @(negedge clk) begin
        if (!rst_n) begin
            host_model_ack = 1'b0;
        end else if (host_normal) begin
            if (bus.tx_req && !host_model_ack) begin
                checkOutput("byte_was_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    checkOutput("host_byte", 32'(bus.tx_data), 32'(exp_q.pop_front()));
                end
                host_model_ack = 1'b1;
            end else if (!bus.tx_req && host_model_ack) begin
                host_model_ack = 1'b0;
            end
        end
    end

    // Offers one word starting at a falling edge; returns at a falling edge.
    task automatic applyStimulus(input logic [15:0] w, input int max_wait, output bit accepted);
        accepted     = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        for (int n = 0; n < max_wait && !accepted; n++) begin
            if (bus.in_ready) begin
                @(posedge clk);
                exp_q.push_back(w[7:0]);
                exp_q.push_back(w[15:8]);
                accepted = 1'b1;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic push_expect(input logic [15:0] w, input string tag);
        bit acc;
        applyStimulus(w, 20, acc);
        checkOutput(tag, 32'(acc), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        for (int n = 0; n < 400; n++) begin
            if (!busy && exp_q.size() == 0 && !bus.host_ack) break;
            @(negedge clk);
        end
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        bit acc;
        bit saw_req;

        // Reset with random inputs.
        rst_n        = 1'b0;
        ena          = 1'b0;
        host_normal  = 1'b1;
        host_force   = 1'b1;
        force_val    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_data  = 16'($urandom);
            force_val    = 1'($urandom_range(0, 1));
        end
        #1;
        checkOutput("reset_tx_data", 32'(bus.tx_data), 32'h00);
        checkOutput("reset_tx_req", 32'(bus.tx_req), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_in_ready_ena0", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        host_force   = 1'b0;
        rst_n        = 1'b1;
        @(negedge clk);
        checkOutput("ena0_in_ready", 32'(bus.in_ready), 32'd0);
        ena = 1'b1;
        #1;
        checkOutput("ena1_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);

        // Single word with minimum latency.
        push_expect(16'hBEEF, "single_accept");
        @(posedge clk);
        #1;
        checkOutput("single_e1_tx_data", 32'(bus.tx_data), 32'hEF);
        checkOutput("single_e1_tx_req", 32'(bus.tx_req), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("single_e2_tx_req", 32'(bus.tx_req), 32'd1);
        @(negedge clk);
        wait_idle("single");

        // Backpressure: host stalls, FIFO fills.
        host_normal = 1'b0;
        for (int w = 1; w <= 5; w++) begin
            push_expect(16'(w), "bp_accept");
        end
        applyStimulus(16'h0006, 6, acc);
        checkOutput("bp_word6_blocked", 32'(acc), 32'd0);
        checkOutput("bp_in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("bp_fifo_count", 32'(fifo_count()), 32'd4);
        checkOutput("bp_tx_req", 32'(bus.tx_req), 32'd1);
        host_normal = 1'b1;
        wait_idle("bp");

        // Stale host ack held before the word arrives.
        host_force = 1'b1;
        force_val  = 1'b1;
        repeat (4) @(negedge clk);
        push_expect(16'h1234, "stale_accept");
        saw_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            saw_req |= bus.tx_req;
            @(negedge clk);
        end
        checkOutput("stale_req_held", 32'(saw_req), 32'd0);
        checkOutput("stale_busy", 32'(busy), 32'd1);
        host_force = 1'b0;
        wait_idle("stale");

        // Push on the same edge as a pop with three words queued.
        host_normal = 1'b0;
        push_expect(16'h1111, "sim_accept_a");
        push_expect(16'h2222, "sim_accept_b");
        push_expect(16'h3333, "sim_accept_c");
        push_expect(16'h4444, "sim_accept_d");
        checkOutput("sim_count_before", 32'(fifo_count()), 32'd3);
        host_normal = 1'b1;
        for (int n = 0; n < 200; n++) begin
            if (dut.state_q == IDLE) break;
            @(negedge clk);
        end
        checkOutput("sim_reached_idle", 32'(dut.state_q == IDLE), 32'd1);
        push_expect(16'h5555, "sim_accept_e");
        checkOutput("sim_count_after", 32'(fifo_count()), 32'd3);
        wait_idle("sim");

        // Reset in the middle of a request with two words queued.
        host_normal = 1'b0;
        push_expect(16'h0A0B, "rst_accept_1");
        push_expect(16'h0C0D, "rst_accept_2");
        push_expect(16'h0E0F, "rst_accept_3");
        for (int n = 0; n < 20; n++) begin
            if (bus.tx_req) break;
            @(negedge clk);
        end
        checkOutput("rst_in_req", 32'(bus.tx_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async_tx_req", 32'(bus.tx_req), 32'd0);
        checkOutput("rst_async_tx_data", 32'(bus.tx_data), 32'h00);
        checkOutput("rst_async_busy", 32'(busy), 32'd0);
        checkOutput("rst_fifo_count", 32'(fifo_count()), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n       = 1'b1;
        host_normal = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_busy", 32'(busy), 32'd0);
        push_expect(16'hA55A, "post_rst_accept");
        wait_idle("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pin_stream_tx.md
# pin_stream_tx

Transmits 16-bit result words from the core to an off-chip host over the Tiny Tapeout pins. Each word is buffered in a small FIFO and sent as two bytes on `uo_out`, LSB byte first, using a four-phase req/ack handshake on the bidirectional pins. It is instantiated inside `tt_um_emersonmde_vilya`. It is the device-to-host counterpart of the host-to-device stimulus path on `ui_in`.

## Interface
- `DATA_W`, 16: word width; fixed at 2 bytes (other values unsupported).
- `DEPTH`, 4: FIFO entries; must be a power of two, ≥2.
- `clk` input 1: single clock; all state is on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `ena` input 1: TT enable; while low, `in_ready`=0 (no new words accepted); an in-flight word still completes.
- `in_valid` input 1: core offers `in_data`.
- `in_ready` output 1: equals `ena & !full`; a word is accepted on a cycle where `in_valid & in_ready`.
- `in_data` input DATA_W: word to send.
- `tx_data` output 8: byte driven to `uo_out`, registered.
- `tx_req` output 1: request strobe to `uio_out[0]`, registered.
- `host_ack` input 1: acknowledge from `uio_in[1]`, asynchronous to `clk`.
- `busy` output 1: `(state != IDLE) | !empty`.

Top level ties `uio_oe[0]`=1 and `uio_oe[1]`=0; that wiring is not part of this block.

## Operation
- **Reset values:**
  - `tx_data`=0x00, `tx_req`=0, `busy`=0.
  - FIFO empty; both ack-synchronizer flops 0.
  - State IDLE; byte index 0.
- **Ack synchronizer:** `host_ack` passes through 2 flops to give `ack_s`. Only `ack_s` is used.
- **FIFO:** pointers are log2(DEPTH)+1 bits and wrap naturally; the extra MSB distinguishes full from empty.
  - Push when `in_valid & in_ready`.
  - Pop only on the IDLE→SETUP transition.
  - Push and pop in the same cycle are legal whenever not full. Count is unchanged.
- **FSM states:**
  - IDLE: if `!empty & !ack_s`, pop the head into a 16-bit `word` register, drive `tx_data` = low byte, set byte index 0, go to SETUP. If `ack_s`=1 here, wait in IDLE (stale host ack).
  - SETUP: one cycle of data setup; `tx_req` 0→1; go to REQ.
  - REQ: hold `tx_data` and `tx_req`=1 until `ack_s`=1. Then drop `tx_req`=0 and go to WAIT_LO.
  - WAIT_LO: wait for `ack_s`=0. Then:
    - If byte index = 0: drive `tx_data` = high byte, set index 1, go to SETUP.
    - If byte index = 1: go to IDLE. `tx_data` keeps the last value.
- `tx_data` changes only on entry to SETUP, so it is stable for the whole time `tx_req` is high.
- **ena low:** FSM and FIFO pop continue; only pushes are blocked.
- **Reset mid-transfer:** everything returns to reset values immediately. `tx_req` drops asynchronously, and queued words are discarded.

## Timing
- **Minimum latency:** word accepted at edge E0 into an empty FIFO in IDLE.
  - E1: `tx_data`=low byte, state SETUP.
  - E2: `tx_req`=1.
- **Ack path:** `host_ack` rising before edge A is visible as `ack_s` after edge A+1. `tx_req` falls at edge A+2.
- **Per byte, with immediate host response:** 2 sync cycles for the ack rise, plus 2 for the ack fall, plus SETUP and REQ overhead ≈ 6 cycles. One word ≈ 12 cycles.
- **Back-to-back words:** WAIT_LO→IDLE→SETUP, which adds one IDLE cycle between words.
- **Full FIFO:** `in_ready`=0 the cycle after the DEPTH-th push. It returns to 1 the cycle after a pop.

## Structure
- Package `vilya_pin_pkg` holds:
  - the `tx_state_t` enum {IDLE, SETUP, REQ, WAIT_LO};
  - the localparams `BYTES_PER_WORD`=2 and `SYNC_STAGES`=2.
- One sub-module, `pin_tx_fifo`: a synchronous FIFO with parameters `WIDTH` and `DEPTH`. It exposes push/pop/full/empty, has asynchronous active-low reset, and shows the head word combinationally.
- FSM, synchronizer and byte mux stay in `pin_stream_tx`.

## Test plan
- **Reset:** hold `rst_n`=0 with random inputs → `tx_data`=0, `tx_req`=0, `busy`=0, `in_ready`=0 while `ena`=0.
- **Single word:** push 0xBEEF with a host model that acks 1 cycle after `tx_req` and releases 1 cycle after `tx_req` falls.
  - Expected: host captures 0xEF then 0xBE.
  - `tx_req` is high 2 edges after acceptance.
  - `busy` returns to 0.
- **Backpressure:** host never acks; push 0x0001..0x0006.
  - Expected: 0x0001 in flight, 4 words queued, `in_ready`=0.
  - Release the host → bytes 01 00 02 00 … 05 00 in order. 0x0006 is never accepted unless re-offered.
- **Stale ack:** hold `host_ack`=1 before pushing 0x1234.
  - Expected: `tx_req` stays 0 until ack drops, then a normal transfer.
- **Simultaneous push/pop:** FIFO at 3 entries, push on the IDLE→SETUP cycle.
  - Expected: count stays 3 and order is preserved.
- **Reset mid-operation:** assert `rst_n`=0 while in REQ with 2 words queued.
  - Expected: `tx_req` falls without waiting for an edge.
  - After release: `busy`=0, FIFO empty, and a new word 0xA55A transfers correctly.
